power_rail_sequencer: RTL and testbench
=======================================

# power_rail_sequencer

Upstream stage of `power_monitoring_unit`. Drives the memory and I/O rail enables through an ordered power-up and power-down sequence, and debounces the rails' power-good inputs. It produces the `seq_state`, `power_status` and `clock_status` signals the PMU monitors. It also consumes the PMU's `temp_alert` for thermal shutdown. Bit 0 is the memory channel and bit 1 is the I/O channel throughout.

## Interface
- `STABLE_CYCLES`, 16: consecutive cycles a pgood must stay high before it counts as good.
- `RAMP_TIMEOUT`, 1000: maximum cycles allowed in any ramp-up or ramp-down state.
- `CNT_W`, 16: width of the timer and the debounce counters.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous reset, active-high.
- `power_on_req`  in  1  level request to power up.
- `power_off_req`  in  1  level request to power down; takes priority over `power_on_req`.
- `mem_pgood`, `io_pgood`  in  1 each  rail power-good, already synchronised.
- `fault_clr`  in  1  one-cycle pulse that clears FAULT.
- `temp_alert`  in  1  from the PMU; used only under the configuration macro.
- `mem_rail_en`, `io_rail_en`  out  1 each  rail enables.
- `seq_state`  out  3  current FSM state encoding.
- `power_status`  out  2  `{io_rail_en & io_good, mem_rail_en & mem_good}`, where `*_good` is the debounced pgood.
- `clock_status`  out  2  2'b11 in RUN, otherwise 2'b00.
- `fault`  out  1  sticky fault flag.
- `thermal_trip`  out  1  sticky; set by a thermal shutdown.

## Operation
- State encoding: OFF=0, MEM_RAMP=1, IO_RAMP=2, RUN=3, CLK_STOP=4, IO_DOWN=5, MEM_DOWN=6, FAULT=7.
- **OFF:** both rails off. If `power_on_req=1` and `power_off_req=0`, go to MEM_RAMP.
- **MEM_RAMP:** `mem_rail_en=1`.
  - `mem_good` → IO_RAMP.
  - `power_off_req` → MEM_DOWN.
  - Timeout → FAULT.
- **IO_RAMP:** both rails enabled.
  - `io_good` → RUN.
  - `power_off_req` → IO_DOWN.
  - Timeout → FAULT.
  - `mem_pgood` low → FAULT.
- **RUN:**
  - Either raw pgood low → FAULT.
  - Otherwise `power_off_req` → CLK_STOP.
- **CLK_STOP:** `clock_status=00`; lasts exactly one cycle, then IO_DOWN.
- **IO_DOWN:** `io_rail_en=0`. Raw `io_pgood` low → MEM_DOWN; timeout → FAULT.
- **MEM_DOWN:** `mem_rail_en=0`. Raw `mem_pgood` low → OFF; timeout → FAULT.
- **FAULT:**
  - Both rails off, `fault=1`.
  - `fault_clr=1` with `power_on_req=0` → OFF, and `fault` clears.
  - `fault_clr` while `power_on_req=1` is ignored.
- **Debounce:**
  - A per-rail counter increments while raw pgood is high and resets to 0 on any low cycle.
  - `*_good` is 1 when the counter reaches `STABLE_CYCLES`; the counter saturates there.
  - The counter is held at 0 while the corresponding rail enable is 0.
- **Timer:**
  - Clears on every state change.
  - In a ramp or down state, FAULT is taken when timer == `RAMP_TIMEOUT-1` and the exit condition is false.
  - If the exit condition and the timeout occur in the same cycle, the exit wins.
- **Reset mid-sequence:** all outputs return to reset values immediately; rails drop with no ordering.

## Timing
- All outputs are registered.
- Reset values: `seq_state=0`, rail enables 0, `power_status=00`, `clock_status=00`, `fault=0`, `thermal_trip=0`.
- A request sampled high at edge N changes state and rail enables at edge N.
- A pgood held high from cycle k sets `*_good` at edge k+`STABLE_CYCLES`. The state advances on the following edge.
- `power_status` and `clock_status` are derived from next-state and next-good values, so they update in the same cycle as `seq_state`.

## Configuration
- `PWR_SEQ_THERMAL_SHUTDOWN_EN` defined:
  - In RUN, `temp_alert=1` acts as `power_off_req` (→ CLK_STOP) and sets `thermal_trip`.
  - In MEM_RAMP or IO_RAMP, `temp_alert=1` aborts power-up exactly as `power_off_req` does.
  - `thermal_trip` clears only on `rst` or `fault_clr`.
- Macro undefined: `temp_alert` is ignored and `thermal_trip` is tied to 0.

## Structure
- `pwr_seq_pkg` holds:
  - the `seq_state_e` enum with the encodings above;
  - the `CH_MEM=0` and `CH_IO=1` bit-index constants.
- Sub-module `pgood_debouncer` (parameters `STABLE_CYCLES`, `CNT_W`) is instantiated once per rail.

## Test plan
All scenarios use `STABLE_CYCLES=4`, `RAMP_TIMEOUT=20`.
- **Power-up:** `power_on_req=1`; `mem_pgood` rises 3 cycles after `mem_rail_en`, `io_pgood` likewise → `seq_state` 1→2→3, `power_status=11`, `clock_status=11`, `fault=0`.
- **Ramp timeout:** `mem_pgood` held 0 → `seq_state=7` exactly 20 cycles after entering MEM_RAMP; `mem_rail_en=0`; `fault=1`. Then `fault_clr` with `power_on_req=0` → `seq_state=0`, `fault=0`.
- **Debounce glitch:** `mem_pgood` high 3 cycles, low 1 cycle, then high → IO_RAMP is entered only after 4 further consecutive high cycles.
- **Orderly off:** from RUN, `power_off_req=1` → 4 (1 cycle, `clock_status=00`) → 5 (`io_rail_en=0`) → after `io_pgood` drops, 6 → after `mem_pgood` drops, 0.
- **Rail collapse:** in RUN, `io_pgood=0` for 1 cycle → `seq_state=7` next edge, both rails 0, `power_status=00`.
- **Thermal (macro on):** in RUN, `temp_alert=1` → CLK_STOP and `thermal_trip=1`, ending in OFF. With the macro off, the same stimulus leaves `seq_state=3`.

Source files
------------

// File: rtl/pwr_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwr_seq_pkg
//  Description : Shared types and constants for the power rail sequencer.
//                Holds the sequencer state encoding and the channel bit
//                indices (bit 0 = memory rail, bit 1 = I/O rail).
//  Revision    : 1.0 - initial release
// ============================================================================
package pwr_seq_pkg;

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_MEM_RAMP = 3'd1,
        S_IO_RAMP  = 3'd2,
        S_RUN      = 3'd3,
        S_CLK_STOP = 3'd4,
        S_IO_DOWN  = 3'd5,
        S_MEM_DOWN = 3'd6,
        S_FAULT    = 3'd7
    } seq_state_e;

    localparam int CH_MEM = 0;
    localparam int CH_IO  = 1;

endpackage
`default_nettype wire

// File: rtl/power_rail_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : power_rail_sequencer_if
//  Description : Control/status bundle between the power rail sequencer and
//                its environment (request/pgood inputs, rail enables and
//                status outputs).
//                master : environment side (drives requests and pgoods)
//                slave  : sequencer side (drives enables and status)
//  Revision    : 1.0 - initial release
// ============================================================================
interface power_rail_sequencer_if;

    logic       power_on_req;
    logic       power_off_req;
    logic       mem_pgood;
    logic       io_pgood;
    logic       fault_clr;
    logic       temp_alert;

    logic       mem_rail_en;
    logic       io_rail_en;
    logic [2:0] seq_state;
    logic [1:0] power_status;
    logic [1:0] clock_status;
    logic       fault;
    logic       thermal_trip;

    modport master (
        output power_on_req, power_off_req, mem_pgood, io_pgood, fault_clr, temp_alert,
        input  mem_rail_en, io_rail_en, seq_state, power_status, clock_status, fault, thermal_trip
    );

    modport slave (
        input  power_on_req, power_off_req, mem_pgood, io_pgood, fault_clr, temp_alert,
        output mem_rail_en, io_rail_en, seq_state, power_status, clock_status, fault, thermal_trip
    );

endinterface
`default_nettype wire

// File: rtl/pgood_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : pgood_debouncer
//  Description : Power-good debouncer for one rail. A counter advances while
//                the raw pgood is high and the rail is enabled, clears on any
//                low cycle or while the rail is disabled, and saturates at
//                STABLE_CYCLES, where the rail is reported good.
//  Ports       : clk, rst     - clock, async active-high reset
//                i_en         - rail enable (counter held at 0 when low)
//                i_pgood      - raw, already synchronised pgood
//                o_good       - registered debounced good
//                o_good_nxt   - value o_good takes at the next edge
//  Revision    : 1.0 - initial release
// ============================================================================
module pgood_debouncer #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_en,
    input  wire logic i_pgood,
    output logic      o_good,
    output logic      o_good_nxt
);

    localparam logic [CNT_W-1:0] c_stable = CNT_W'(STABLE_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_good;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!i_en || !i_pgood) begin
            w_cnt_nxt = '0;
        end else if (r_cnt != c_stable) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // Exposed so the parent can register status bits that track good
    // in the same cycle rather than one cycle late.
    assign o_good_nxt = (w_cnt_nxt == c_stable);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_good <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_good <= o_good_nxt;
        end
    end

    assign o_good = r_good;

endmodule
`default_nettype wire

// File: rtl/power_rail_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : power_rail_sequencer
//  Description : Ordered power-up / power-down of the memory and I/O rails
//                with debounced power-good, ramp timeouts and a sticky fault.
//                Optional thermal shutdown is compiled in when the macro
//                PWR_SEQ_THERMAL_SHUTDOWN_EN is defined; otherwise
//                temp_alert is ignored and thermal_trip is tied low.
//  Ports       : clk  - system clock
//                rst  - asynchronous active-high reset
//                bus  - power_rail_sequencer_if.slave (requests, pgoods,
//                       fault_clr, temp_alert in; rail enables, seq_state,
//                       power_status, clock_status, fault, thermal_trip out)
//  Revision    : 1.0 - initial release
// ============================================================================
module power_rail_sequencer
    import pwr_seq_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int RAMP_TIMEOUT  = 1000,
    parameter int CNT_W         = 16
) (
    input wire logic               clk,
    input wire logic               rst,
    power_rail_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(RAMP_TIMEOUT - 1);

    seq_state_e       r_state;
    seq_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_timer;
    logic [1:0]       w_pgood;
    logic [1:0]       w_good;
    logic [1:0]       w_good_nxt;
    logic [1:0]       r_rail_en;
    logic [1:0]       w_rail_en_nxt;
    logic [1:0]       r_power_status;
    logic [1:0]       r_clock_status;
    logic             r_fault;
    logic             w_timeout;
    logic             w_temp;
    logic             w_abort;

    assign w_pgood[CH_MEM] = bus.mem_pgood;
    assign w_pgood[CH_IO]  = bus.io_pgood;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_rail
            pgood_debouncer #(
                .STABLE_CYCLES (STABLE_CYCLES),
                .CNT_W         (CNT_W)
            ) u_debouncer (
                .clk        (clk),
                .rst        (rst),
                .i_en       (r_rail_en[g]),
                .i_pgood    (w_pgood[g]),
                .o_good     (w_good[g]),
                .o_good_nxt (w_good_nxt[g])
            );
        end
    endgenerate

`ifdef PWR_SEQ_THERMAL_SHUTDOWN_EN
    logic r_thermal_trip;
    logic w_trip_set;

    assign w_temp = bus.temp_alert;
    // Only a shutdown actually taken from RUN latches the trip; a rail
    // collapse in the same cycle goes to FAULT instead.
    assign w_trip_set = (r_state == S_RUN) && (w_pgood == 2'b11) && w_temp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_thermal_trip <= 1'b0;
        end else if (w_trip_set) begin
            r_thermal_trip <= 1'b1;
        end else if (bus.fault_clr) begin
            r_thermal_trip <= 1'b0;
        end
    end

    assign bus.thermal_trip = r_thermal_trip;
`else
    logic w_unused_temp;
    assign w_unused_temp    = bus.temp_alert;
    assign w_temp           = 1'b0;
    assign bus.thermal_trip = 1'b0;
`endif

    // A thermal alert aborts power-up / forces power-down exactly like an
    // explicit off request.
    assign w_abort   = bus.power_off_req | w_temp;
    assign w_timeout = (r_timer == c_timeout_last);

    // In every timed state the exit conditions are tested before the
    // timeout so that an exit coinciding with expiry wins.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_OFF: begin
                if (bus.power_on_req && !bus.power_off_req) w_state_nxt = S_MEM_RAMP;
            end
            S_MEM_RAMP: begin
                if (w_good[CH_MEM])  w_state_nxt = S_IO_RAMP;
                else if (w_abort)    w_state_nxt = S_MEM_DOWN;
                else if (w_timeout)  w_state_nxt = S_FAULT;
            end
            S_IO_RAMP: begin
                if (w_good[CH_IO])                         w_state_nxt = S_RUN;
                else if (w_abort)                          w_state_nxt = S_IO_DOWN;
                else if (!w_pgood[CH_MEM] || w_timeout)    w_state_nxt = S_FAULT;
            end
            S_RUN: begin
                if (w_pgood != 2'b11) w_state_nxt = S_FAULT;
                else if (w_abort)     w_state_nxt = S_CLK_STOP;
            end
            S_CLK_STOP: begin
                w_state_nxt = S_IO_DOWN;
            end
            S_IO_DOWN: begin
                if (!w_pgood[CH_IO]) w_state_nxt = S_MEM_DOWN;
                else if (w_timeout)  w_state_nxt = S_FAULT;
            end
            S_MEM_DOWN: begin
                if (!w_pgood[CH_MEM]) w_state_nxt = S_OFF;
                else if (w_timeout)   w_state_nxt = S_FAULT;
            end
            S_FAULT: begin
                if (bus.fault_clr && !bus.power_on_req) w_state_nxt = S_OFF;
            end
            default: begin
                w_state_nxt = S_FAULT;
            end
        endcase
    end

    always_comb begin
        w_rail_en_nxt         = 2'b00;
        w_rail_en_nxt[CH_MEM] = w_state_nxt inside {S_MEM_RAMP, S_IO_RAMP, S_RUN, S_CLK_STOP, S_IO_DOWN};
        w_rail_en_nxt[CH_IO]  = w_state_nxt inside {S_IO_RAMP, S_RUN, S_CLK_STOP};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_OFF;
            r_timer        <= '0;
            r_rail_en      <= 2'b00;
            r_power_status <= 2'b00;
            r_clock_status <= 2'b00;
            r_fault        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_timer        <= (w_state_nxt != r_state) ? '0 : r_timer + 1'b1;
            r_rail_en      <= w_rail_en_nxt;
            r_power_status <= w_rail_en_nxt & w_good_nxt;
            r_clock_status <= (w_state_nxt == S_RUN) ? 2'b11 : 2'b00;
            r_fault        <= (w_state_nxt == S_FAULT);
        end
    end

    assign bus.seq_state    = r_state;
    assign bus.mem_rail_en  = r_rail_en[CH_MEM];
    assign bus.io_rail_en   = r_rail_en[CH_IO];
    assign bus.power_status = r_power_status;
    assign bus.clock_status = r_clock_status;
    assign bus.fault        = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_power_rail_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_power_rail_sequencer
//  Description : Self-checking bench for power_rail_sequencer. A reference
//                model predicts the output word each cycle and queues it; a
//                monitor on the falling edge pops and compares. Directed
//                scenarios add constant-valued checks on top.
//                Honours PWR_SEQ_THERMAL_SHUTDOWN_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_power_rail_sequencer;

    localparam int ST = 4;
    localparam int RT = 20;
`ifdef PWR_SEQ_THERMAL_SHUTDOWN_EN
    localparam bit THERM = 1'b1;
`else
    localparam bit THERM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    power_rail_sequencer_if bus ();

    power_rail_sequencer #(
        .STABLE_CYCLES (ST),
        .RAMP_TIMEOUT  (RT),
        .CNT_W         (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Output word: {seq_state[2:0], mem_en, io_en, power_status[1:0], clock_status[1:0], fault, thermal_trip}
    logic [10:0] exp_q[$];
    int  m_state, m_timer;
    int  m_cnt[2];
    bit  m_en[2];
    bit  m_fault, m_trip, armed;

    task automatic model_reset();
        m_state = 0; m_timer = 0; m_cnt[0] = 0; m_cnt[1] = 0;
        m_en[0] = 0; m_en[1] = 0; m_fault = 0; m_trip = 0; armed = 0;
    endtask

    task automatic model_step();
        bit pg[2];
        bit good[2];
        bit abort, expired, thermal, trip_set;
        int nxt;
        logic [1:0] ps;
        pg[0]   = bus.mem_pgood;
        pg[1]   = bus.io_pgood;
        good[0] = (m_cnt[0] >= ST);
        good[1] = (m_cnt[1] >= ST);
        thermal = THERM && bus.temp_alert;
        abort   = bus.power_off_req || thermal;
        expired = (m_timer == RT - 1);
        trip_set = 0;
        nxt = m_state;
        case (m_state)
            0: if (bus.power_on_req && !bus.power_off_req) nxt = 1;
            1: if (good[0]) nxt = 2; else if (abort) nxt = 6; else if (expired) nxt = 7;
            2: if (good[1]) nxt = 3; else if (abort) nxt = 5; else if (!pg[0] || expired) nxt = 7;
            3: if (!pg[0] || !pg[1]) nxt = 7; else if (abort) begin nxt = 4; trip_set = thermal; end
            4: nxt = 5;
            5: if (!pg[1]) nxt = 6; else if (expired) nxt = 7;
            6: if (!pg[0]) nxt = 0; else if (expired) nxt = 7;
            default: if (bus.fault_clr && !bus.power_on_req) nxt = 0;
        endcase
        for (int i = 0; i < 2; i++)
            m_cnt[i] = (m_en[i] && pg[i]) ? ((m_cnt[i] < ST) ? m_cnt[i] + 1 : ST) : 0;
        m_timer = (nxt != m_state) ? 0 : m_timer + 1;
        m_state = nxt;
        m_en[0] = (nxt >= 1 && nxt <= 5);
        m_en[1] = (nxt >= 2 && nxt <= 4);
        m_fault = (nxt == 7);
        if (trip_set) m_trip = 1;
        else if (bus.fault_clr) m_trip = 0;
        ps = {m_en[1] && (m_cnt[1] == ST), m_en[0] && (m_cnt[0] == ST)};
        exp_q.push_back({3'(m_state), m_en[0], m_en[1], ps, (m_state == 3) ? 2'b11 : 2'b00, m_fault, m_trip});
        armed = 1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
            exp_q.delete();
        end else begin
            model_step();
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [10:0] act;
        logic [10:0] exp;
        act = {bus.seq_state, bus.mem_rail_en, bus.io_rail_en, bus.power_status,
               bus.clock_status, bus.fault, bus.thermal_trip};
        if (rst || !armed) begin
            check("reset_outputs", 32'(act), 32'd0);
        end else if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            check("scoreboard", 32'(act), 32'(exp));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.power_on_req = 0; bus.power_off_req = 0; bus.mem_pgood = 0;
        bus.io_pgood = 0; bus.fault_clr = 0; bus.temp_alert = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int n = 0;
        while (int'(bus.seq_state) != s && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(bus.seq_state), 32'(s));
    endtask

    task automatic power_up();
        bus.power_on_req = 1;
        tick();
        check("pu_mem_ramp", 32'(bus.seq_state), 32'd1);
        check("pu_mem_en", 32'(bus.mem_rail_en), 32'd1);
        tick(); tick();
        bus.mem_pgood = 1;
        wait_state(2, 20, "pu_io_ramp");
        tick(); tick();
        bus.io_pgood = 1;
        wait_state(3, 20, "pu_run");
        check("pu_power_status", 32'(bus.power_status), 32'd3);
        check("pu_clock_status", 32'(bus.clock_status), 32'd3);
        check("pu_fault", 32'(bus.fault), 32'd0);
    endtask

    initial begin
        clear_inputs();
        do_reset();
        check("reset_state", 32'(bus.seq_state), 32'd0);

        // Power-up then orderly power-down
        power_up();
        bus.power_on_req = 0;
        bus.power_off_req = 1;
        tick();
        check("off_clk_stop", 32'(bus.seq_state), 32'd4);
        check("off_clk_status", 32'(bus.clock_status), 32'd0);
        tick();
        check("off_io_down", 32'(bus.seq_state), 32'd5);
        check("off_io_en", 32'({bus.mem_rail_en, bus.io_rail_en}), 32'd2);
        bus.io_pgood = 0;
        tick();
        check("off_mem_down", 32'(bus.seq_state), 32'd6);
        bus.mem_pgood = 0;
        tick();
        check("off_done", 32'(bus.seq_state), 32'd0);
        bus.power_off_req = 0;

        // Ramp timeout: exactly RT cycles in MEM_RAMP
        do_reset();
        bus.power_on_req = 1;
        tick();
        begin
            int n = 0;
            while (int'(bus.seq_state) == 1 && n < 100) begin
                tick();
                n++;
            end
            check("timeout_cycles", 32'(n), 32'd20);
        end
        check("timeout_state", 32'(bus.seq_state), 32'd7);
        check("timeout_rails", 32'({bus.mem_rail_en, bus.io_rail_en}), 32'd0);
        check("timeout_fault", 32'(bus.fault), 32'd1);
        bus.fault_clr = 1;
        tick();
        bus.fault_clr = 0;
        check("clr_ignored_while_on", 32'(bus.seq_state), 32'd7);
        bus.power_on_req = 0;
        bus.fault_clr = 1;
        tick();
        bus.fault_clr = 0;
        check("clr_state", 32'(bus.seq_state), 32'd0);
        check("clr_fault", 32'(bus.fault), 32'd0);

        // Debounce glitch: 3 high, 1 low, then needs 4 fresh highs
        do_reset();
        bus.power_on_req = 1;
        tick();
        bus.mem_pgood = 1;
        tick(); tick(); tick();
        bus.mem_pgood = 0;
        tick();
        check("glitch_no_early", 32'(bus.seq_state), 32'd1);
        bus.mem_pgood = 1;
        tick(); tick(); tick(); tick();
        check("glitch_hold", 32'(bus.seq_state), 32'd1);
        tick();
        check("glitch_advance", 32'(bus.seq_state), 32'd2);

        // Rail collapse in RUN
        do_reset();
        power_up();
        bus.io_pgood = 0;
        tick();
        bus.io_pgood = 1;
        check("collapse_state", 32'(bus.seq_state), 32'd7);
        check("collapse_rails", 32'({bus.mem_rail_en, bus.io_rail_en}), 32'd0);
        check("collapse_status", 32'(bus.power_status), 32'd0);

        // Thermal alert in RUN
        do_reset();
        power_up();
        bus.temp_alert = 1;
        tick();
        bus.temp_alert = 0;
        if (THERM) begin
            check("thermal_state", 32'(bus.seq_state), 32'd4);
            check("thermal_trip", 32'(bus.thermal_trip), 32'd1);
            bus.power_on_req = 0;
            tick();
            bus.io_pgood = 0;
            tick();
            bus.mem_pgood = 0;
            wait_state(0, 10, "thermal_to_off");
            check("thermal_sticky", 32'(bus.thermal_trip), 32'd1);
        end else begin
            check("thermal_ignored_state", 32'(bus.seq_state), 32'd3);
            check("thermal_ignored_trip", 32'(bus.thermal_trip), 32'd0);
        end

        // Asynchronous reset mid-sequence
        do_reset();
        bus.power_on_req = 1;
        tick(); tick();
        rst = 1'b1;
        #1;
        check("async_reset", 32'({bus.seq_state, bus.mem_rail_en, bus.io_rail_en, bus.power_status,
                                  bus.clock_status, bus.fault, bus.thermal_trip}), 32'd0);
        tick();
        rst = 1'b0;
        clear_inputs();

        // Randomized phase, checked by the scoreboard
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) bus.power_on_req = ~bus.power_on_req;
            if ($urandom_range(0, 79) == 0) bus.power_off_req = ~bus.power_off_req;
            bus.fault_clr  = ($urandom_range(0, 29) == 0);
            bus.temp_alert = ($urandom_range(0, 149) == 0);
            bus.mem_pgood  = bus.mem_rail_en ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0);
            bus.io_pgood   = bus.io_rail_en  ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        clear_inputs();
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
